// File: rtl/jtkiwi_shrarb_if.sv
// jtkiwi_shrarb_if
// Bundles the shared-RAM arbiter bus: both CPU request/response ports plus the
// single-port RAM port and the busy flag.
//   main_* : main Z80 request (cs/rnw/addr/din in, dout/ack out of the arbiter)
//   sub_*  : sub/sound Z80 request, same shape as main_*
//   ram_*  : synchronous RAM port (addr/din/we out of the arbiter, dout in)
//   busy   : arbiter in the ADDR or DATA phase
// Modports: slave = the arbiter, master = CPUs + RAM side.
interface jtkiwi_shrarb_if #(
  parameter int AW = 13,
  parameter int DW = 8
);
  logic          main_cs;
  logic          main_rnw;
  logic [AW-1:0] main_addr;
  logic [DW-1:0] main_din;
  logic [DW-1:0] main_dout;
  logic          main_ack;

  logic          sub_cs;
  logic          sub_rnw;
  logic [AW-1:0] sub_addr;
  logic [DW-1:0] sub_din;
  logic [DW-1:0] sub_dout;
  logic          sub_ack;

  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic          ram_we;
  logic [DW-1:0] ram_dout;

  logic          busy;

  modport slave (
    input  main_cs, main_rnw, main_addr, main_din,
    output main_dout, main_ack,
    input  sub_cs, sub_rnw, sub_addr, sub_din,
    output sub_dout, sub_ack,
    output ram_addr, ram_din, ram_we,
    input  ram_dout,
    output busy
  );

  modport master (
    output main_cs, main_rnw, main_addr, main_din,
    input  main_dout, main_ack,
    output sub_cs, sub_rnw, sub_addr, sub_din,
    input  sub_dout, sub_ack,
    input  ram_addr, ram_din, ram_we,
    output ram_dout,
    input  busy
  );
endinterface

// File: rtl/jtkiwi_shrarb.sv
// jtkiwi_shrarb
// Serialises main and sub Z80 accesses onto the single-port synchronous 8 kB
// shared RAM. Each access takes IDLE(grant) -> ADDR -> DATA -> IDLE, with the
// ack pulse and read data presented in the cycle after DATA.
// Ports:
//   clk      : 24 MHz CPU clock
//   rstn     : asynchronous active-low reset
//   sub_rstn : sub CPU running; low masks sub requests and suppresses its ack
//   bus      : jtkiwi_shrarb_if.slave (main_*, sub_*, ram_*, busy)
// Build option: define JTKIWI_SHRARB_FAIR_EN for round-robin arbitration;
// otherwise main has fixed priority.
module jtkiwi_shrarb #(
  parameter int AW = 13,
  parameter int DW = 8
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           sub_rstn,
  jtkiwi_shrarb_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_t;

  state_t        r_state;
  logic          r_sel_sub;
  logic          r_rnw;
  logic [AW-1:0] r_ram_addr;
  logic [DW-1:0] r_ram_din;
  logic          r_ram_we;
  logic [DW-1:0] r_main_dout;
  logic [DW-1:0] r_sub_dout;
  logic          r_main_ack;
  logic          r_sub_ack;
  logic          r_main_done;
  logic          r_sub_done;
  logic          r_busy;
`ifdef JTKIWI_SHRARB_FAIR_EN
  logic          r_next_sub;   // 1 = sub wins the next simultaneous request
`endif

  logic          w_main_elig;
  logic          w_sub_elig;
  logic          w_req;
  logic          w_pick_sub;
  logic          w_rnw;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_din;

  always_comb begin
    w_main_elig = bus.main_cs & ~r_main_done;
    w_sub_elig  = bus.sub_cs & ~r_sub_done & sub_rstn;
    w_req       = w_main_elig | w_sub_elig;
`ifdef JTKIWI_SHRARB_FAIR_EN
    w_pick_sub  = w_sub_elig & (~w_main_elig | r_next_sub);
`else
    w_pick_sub  = w_sub_elig & ~w_main_elig;
`endif
    w_rnw  = w_pick_sub ? bus.sub_rnw  : bus.main_rnw;
    w_addr = w_pick_sub ? bus.sub_addr : bus.main_addr;
    w_din  = w_pick_sub ? bus.sub_din  : bus.main_din;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_sel_sub   <= 1'b0;
      r_rnw       <= 1'b1;
      r_ram_addr  <= '0;
      r_ram_din   <= '0;
      r_ram_we    <= 1'b0;
      r_main_dout <= '0;
      r_sub_dout  <= '0;
      r_main_ack  <= 1'b0;
      r_sub_ack   <= 1'b0;
      r_main_done <= 1'b0;
      r_sub_done  <= 1'b0;
      r_busy      <= 1'b0;
`ifdef JTKIWI_SHRARB_FAIR_EN
      r_next_sub  <= 1'b0;
`endif
    end else begin
      r_main_ack <= 1'b0;
      r_sub_ack  <= 1'b0;
      r_ram_we   <= 1'b0;

      // done clears whenever cs is low; a set in DATA below overrides this
      // (cs is necessarily high while its transaction is in flight).
      if (!bus.main_cs)
        r_main_done <= 1'b0;
      if (!bus.sub_cs || !sub_rstn)
        r_sub_done <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_sel_sub  <= w_pick_sub;
            r_rnw      <= w_rnw;
            r_ram_addr <= w_addr;
            r_ram_din  <= w_din;
            r_ram_we   <= ~w_rnw;
            r_busy     <= 1'b1;
            r_state    <= S_ADDR;
`ifdef JTKIWI_SHRARB_FAIR_EN
            r_next_sub <= ~w_pick_sub;
`endif
          end
        end
        S_ADDR: begin
          r_state <= S_DATA;
        end
        S_DATA: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          if (r_sel_sub) begin
            // A sub CPU put into reset mid-access gets no ack; the RAM side
            // of the access has already completed.
            if (sub_rstn) begin
              r_sub_ack  <= 1'b1;
              r_sub_done <= 1'b1;
              if (r_rnw)
                r_sub_dout <= bus.ram_dout;
            end
          end else begin
            r_main_ack  <= 1'b1;
            r_main_done <= 1'b1;
            if (r_rnw)
              r_main_dout <= bus.ram_dout;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ram_addr  = r_ram_addr;
  assign bus.ram_din   = r_ram_din;
  assign bus.ram_we    = r_ram_we;
  assign bus.main_dout = r_main_dout;
  assign bus.main_ack  = r_main_ack;
  assign bus.sub_dout  = r_sub_dout;
  assign bus.sub_ack   = r_sub_ack;
  assign bus.busy      = r_busy;

endmodule
